// File: rtl/project_cfg_pkg.sv
// Shared types and helpers for the Warships game-flow sequencer.
// Coordinates are {x[3:0], y[3:0]}; 8'hff means "no cell selected".
package project_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      PLACE       = 3'd1,
      READY       = 3'd2,
      PLAYER_TURN = 3'd3,
      SHOT_WAIT   = 3'd4,
      ENEMY_TURN  = 3'd5,
      WIN         = 3'd6,
      LOSE        = 3'd7
   } turn_state_t;

   localparam int          GRID_CELLS = 10;
   localparam logic [7:0]  COR_NONE   = 8'hff;

   // Linear cell index y*10 + x; only meaningful for a valid coordinate.
   function automatic logic [6:0] cell_idx(input logic [7:0] cor);
      return 7'(cor[3:0]) * 7'(GRID_CELLS) + 7'(cor[7:4]);
   endfunction

   function automatic logic [4:0] sat_inc5(input logic [4:0] v);
      return (v == 5'h1f) ? v : v + 5'd1;
   endfunction

endpackage

// File: rtl/click_edge_det.sv
// Turns a held coordinate level into a one-cycle click pulse and flags
// whether the coordinate lies on the 10x10 grid.
module click_edge_det
   import project_cfg_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] i_cor,
   output logic       o_click,
   output logic       o_cor_valid
);

   logic [7:0] r_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_prev <= COR_NONE;
      else     r_prev <= i_cor;
   end

   assign o_click     = (i_cor != COR_NONE) && (r_prev == COR_NONE);
   assign o_cor_valid = (i_cor[7:4] <= 4'(GRID_CELLS - 1)) &&
                        (i_cor[3:0] <= 4'(GRID_CELLS - 1));

endmodule

// File: rtl/turn_ctrl.sv
// Warships game-flow sequencer: placement, turn alternation, win/lose,
// with registered request/ack handshakes to the board memory and the link.
module turn_ctrl
   import project_cfg_pkg::*;
#(
   parameter int SHIP_CELLS  = 20,
   parameter int HITS_TO_WIN = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_btn,
   input  logic [7:0] player_cor,
   input  logic [7:0] enemy_cor,
   input  logic       first_move,
   output logic       place_req,
   output logic [7:0] place_cor,
   input  logic       place_ack,
   input  logic       place_ok,
   output logic       shot_req,
   output logic [7:0] shot_cor,
   input  logic       shot_ack,
   input  logic       shot_hit,
   input  logic       enemy_shot_valid,
   input  logic       enemy_shot_hit,
   output logic [2:0] state,
   output logic [4:0] placed_cnt,
   output logic [4:0] player_hits,
   output logic [4:0] enemy_hits
);

   turn_state_t r_state, w_state_nxt;
   logic        r_place_req, w_place_req_nxt;
   logic [7:0]  r_place_cor, w_place_cor_nxt;
   logic        r_shot_req, w_shot_req_nxt;
   logic [7:0]  r_shot_cor, w_shot_cor_nxt;
   logic [4:0]  r_placed_cnt, w_placed_cnt_nxt;
   logic [4:0]  r_player_hits, w_player_hits_nxt;
   logic [4:0]  r_enemy_hits, w_enemy_hits_nxt;
   logic [99:0] r_shot_map, w_shot_map_nxt;
   logic        r_start_prev;

   logic        w_start_press;
   logic        w_p_click, w_p_valid;
   logic        w_e_click, w_e_valid;
   logic [6:0]  w_e_idx;

   click_edge_det u_player_edge (
      .clk         (clk),
      .rst         (rst),
      .i_cor       (player_cor),
      .o_click     (w_p_click),
      .o_cor_valid (w_p_valid)
   );

   click_edge_det u_enemy_edge (
      .clk         (clk),
      .rst         (rst),
      .i_cor       (enemy_cor),
      .o_click     (w_e_click),
      .o_cor_valid (w_e_valid)
   );

   assign w_start_press = start_btn && !r_start_prev;
   assign w_e_idx       = cell_idx(enemy_cor);

   always_comb begin
      // NOTE: every next-value gets its hold default first, so no path can infer a latch.
      w_state_nxt       = r_state;
      w_place_req_nxt   = r_place_req;
      w_place_cor_nxt   = r_place_cor;
      w_shot_req_nxt    = r_shot_req;
      w_shot_cor_nxt    = r_shot_cor;
      w_placed_cnt_nxt  = r_placed_cnt;
      w_player_hits_nxt = r_player_hits;
      w_enemy_hits_nxt  = r_enemy_hits;
      w_shot_map_nxt    = r_shot_map;

      case (r_state)
         IDLE: if (w_start_press) w_state_nxt = PLACE;

         PLACE: begin
            // A click is only taken while idle on the bus, so a click in the ack cycle is lost.
            if (r_place_req) begin
               if (place_ack) begin
                  w_place_req_nxt = 1'b0;
                  if (place_ok) begin
                     w_placed_cnt_nxt = sat_inc5(r_placed_cnt);
                     if (w_placed_cnt_nxt == 5'(SHIP_CELLS)) w_state_nxt = READY;
                  end
               end
            end else if (w_p_click && w_p_valid) begin
               w_place_req_nxt = 1'b1;
               w_place_cor_nxt = player_cor;
            end
         end

         READY: if (w_start_press) w_state_nxt = first_move ? PLAYER_TURN : ENEMY_TURN;

         PLAYER_TURN: begin
            if (w_e_click && w_e_valid && !r_shot_map[w_e_idx]) begin
               w_shot_map_nxt[w_e_idx] = 1'b1;
               w_shot_cor_nxt          = enemy_cor;
               w_shot_req_nxt          = 1'b1;
               w_state_nxt             = SHOT_WAIT;
            end
         end

         SHOT_WAIT: begin
            if (r_shot_req && shot_ack) begin
               w_shot_req_nxt = 1'b0;
               if (shot_hit) begin
                  w_player_hits_nxt = sat_inc5(r_player_hits);
                  w_state_nxt = (w_player_hits_nxt == 5'(HITS_TO_WIN)) ? WIN : PLAYER_TURN;
               end else begin
                  w_state_nxt = ENEMY_TURN;
               end
            end
         end

         ENEMY_TURN: begin
            if (enemy_shot_valid) begin
               if (enemy_shot_hit) begin
                  w_enemy_hits_nxt = sat_inc5(r_enemy_hits);
                  if (w_enemy_hits_nxt == 5'(HITS_TO_WIN)) w_state_nxt = LOSE;
               end else begin
                  w_state_nxt = PLAYER_TURN;
               end
            end
         end

         WIN, LOSE: begin
            if (w_start_press) begin
               w_state_nxt       = IDLE;
               w_placed_cnt_nxt  = '0;
               w_player_hits_nxt = '0;
               w_enemy_hits_nxt  = '0;
               w_shot_map_nxt    = '0;
            end
         end

         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state uses non-blocking updates; shot_map is a plain register and is reset with the rest.
      if (rst) begin
         r_state       <= IDLE;
         r_place_req   <= 1'b0;
         r_place_cor   <= COR_NONE;
         r_shot_req    <= 1'b0;
         r_shot_cor    <= COR_NONE;
         r_placed_cnt  <= '0;
         r_player_hits <= '0;
         r_enemy_hits  <= '0;
         r_shot_map    <= '0;
         r_start_prev  <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_place_req   <= w_place_req_nxt;
         r_place_cor   <= w_place_cor_nxt;
         r_shot_req    <= w_shot_req_nxt;
         r_shot_cor    <= w_shot_cor_nxt;
         r_placed_cnt  <= w_placed_cnt_nxt;
         r_player_hits <= w_player_hits_nxt;
         r_enemy_hits  <= w_enemy_hits_nxt;
         r_shot_map    <= w_shot_map_nxt;
         r_start_prev  <= start_btn;
      end
   end

   assign state       = r_state;
   assign place_req   = r_place_req;
   assign place_cor   = r_place_cor;
   assign shot_req    = r_shot_req;
   assign shot_cor    = r_shot_cor;
   assign placed_cnt  = r_placed_cnt;
   assign player_hits = r_player_hits;
   assign enemy_hits  = r_enemy_hits;

endmodule

// File: tb/tb_turn_ctrl.sv
// Scenario bench for turn_ctrl: expected request cells go into scoreboard
// queues when clicks are driven and are popped when the request appears.
module tb_turn_ctrl;
   import project_cfg_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_btn, first_move;
   logic [7:0] player_cor, enemy_cor;
   logic       place_req, place_ack, place_ok;
   logic [7:0] place_cor;
   logic       shot_req, shot_ack, shot_hit;
   logic [7:0] shot_cor;
   logic       enemy_shot_valid, enemy_shot_hit;
   logic [2:0] state;
   logic [4:0] placed_cnt, player_hits, enemy_hits;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_place_q[$];
   logic [7:0] exp_shot_q[$];
   logic [4:0] m_placed, m_phits, m_ehits;

   turn_ctrl #(.SHIP_CELLS(20), .HITS_TO_WIN(20)) dut (
      .clk              (clk),
      .rst              (rst),
      .start_btn        (start_btn),
      .player_cor       (player_cor),
      .enemy_cor        (enemy_cor),
      .first_move       (first_move),
      .place_req        (place_req),
      .place_cor        (place_cor),
      .place_ack        (place_ack),
      .place_ok         (place_ok),
      .shot_req         (shot_req),
      .shot_cor         (shot_cor),
      .shot_ack         (shot_ack),
      .shot_hit         (shot_hit),
      .enemy_shot_valid (enemy_shot_valid),
      .enemy_shot_hit   (enemy_shot_hit),
      .state            (state),
      .placed_cnt       (placed_cnt),
      .player_hits      (player_hits),
      .enemy_hits       (enemy_hits)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_start();
      start_btn = 1'b1;
      tick(1);
      start_btn = 1'b0;
      tick(1);
   endtask

   // Click a player cell, wait for the request, check it against the scoreboard, then ack it.
   task automatic place_one(input logic [7:0] c, input bit ok);
      int waited;
      logic [7:0] e;
      exp_place_q.push_back(c);
      player_cor = c;
      tick(1);
      player_cor = COR_NONE;
      waited = 0;
      while (!place_req && waited < 8) begin
         tick(1);
         waited++;
      end
      e = exp_place_q.pop_front();
      total++;
      if (place_req !== 1'b1) begin
         bad++;
         $display("FAIL place_req_timeout cell=%h got=%b want=1", c, place_req);
      end
      total++;
      if (place_cor !== e) begin
         bad++;
         $display("FAIL place_cor got=%h want=%h", place_cor, e);
      end
      place_ack = 1'b1;
      place_ok  = ok;
      tick(1);
      place_ack = 1'b0;
      place_ok  = 1'b0;
      if (ok && m_placed != 5'h1f) m_placed++;
   endtask

   task automatic fill_cells(input int from, input int to);
      for (int i = from; i <= to; i++) begin
         logic [3:0] x, y;
         x = 4'(i % 10);
         y = 4'(i / 10);
         place_one({x, y}, 1'b1);
      end
   endtask

   task automatic shot_click(input logic [7:0] c);
      int waited;
      logic [7:0] e;
      exp_shot_q.push_back(c);
      enemy_cor = c;
      tick(1);
      enemy_cor = COR_NONE;
      waited = 0;
      while (!shot_req && waited < 8) begin
         tick(1);
         waited++;
      end
      e = exp_shot_q.pop_front();
      total++;
      if (shot_req !== 1'b1) begin
         bad++;
         $display("FAIL shot_req_timeout cell=%h got=%b want=1", c, shot_req);
      end
      total++;
      if (shot_cor !== e) begin
         bad++;
         $display("FAIL shot_cor got=%h want=%h", shot_cor, e);
      end
   endtask

   task automatic shot_answer(input bit hit);
      shot_ack = 1'b1;
      shot_hit = hit;
      tick(1);
      shot_ack = 1'b0;
      shot_hit = 1'b0;
      if (hit && m_phits != 5'h1f) m_phits++;
   endtask

   task automatic enemy_strobe(input bit hit);
      enemy_shot_valid = 1'b1;
      enemy_shot_hit   = hit;
      tick(1);
      enemy_shot_valid = 1'b0;
      enemy_shot_hit   = 1'b0;
      if (hit && m_ehits != 5'h1f) m_ehits++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(2);
      total++;
      if (state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", state, IDLE); end
      total++;
      if ({place_req, shot_req} !== 2'b00) begin
         bad++; $display("FAIL reset_reqs got=%b want=00", {place_req, shot_req});
      end
      total++;
      if ({place_cor, shot_cor} !== {COR_NONE, COR_NONE}) begin
         bad++; $display("FAIL reset_cors got=%h want=ffff", {place_cor, shot_cor});
      end
      total++;
      if ({placed_cnt, player_hits, enemy_hits} !== 15'd0) begin
         bad++; $display("FAIL reset_counters got=%h want=0", {placed_cnt, player_hits, enemy_hits});
      end
      rst = 1'b0;
      tick(1);
   endtask

   task automatic test_start();
      int changes;
      logic [2:0] prev;
      changes = 0;
      prev = state;
      start_btn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         if (state !== prev) changes++;
         prev = state;
      end
      start_btn = 1'b0;
      tick(2);
      total++;
      if (changes != 1) begin bad++; $display("FAIL start_transitions got=%0d want=1", changes); end
      total++;
      if (state !== PLACE) begin bad++; $display("FAIL start_state got=%0d want=%0d", state, PLACE); end
      total++;
      if (place_req !== 1'b0) begin bad++; $display("FAIL start_place_req got=%b want=0", place_req); end
   endtask

   task automatic test_placement();
      logic [7:0] e;
      exp_place_q.push_back(8'h23);
      player_cor = 8'h23;
      tick(3);
      e = exp_place_q.pop_front();
      total++;
      if (place_req !== 1'b1 || place_cor !== e) begin
         bad++; $display("FAIL held_click_req got=%b/%h want=1/%h", place_req, place_cor, e);
      end
      tick(7);
      place_ack = 1'b1;
      place_ok  = 1'b1;
      tick(1);
      place_ack = 1'b0;
      place_ok  = 1'b0;
      m_placed = 5'd1;
      total++;
      if (place_req !== 1'b0 || placed_cnt !== m_placed) begin
         bad++; $display("FAIL place_ack got=%b/%0d want=0/%0d", place_req, placed_cnt, m_placed);
      end
      player_cor = COR_NONE;
      tick(3);
      total++;
      if (place_req !== 1'b0) begin bad++; $display("FAIL held_single_req got=%b want=0", place_req); end
      player_cor = 8'hA3;
      tick(1);
      player_cor = COR_NONE;
      tick(3);
      total++;
      if (place_req !== 1'b0) begin bad++; $display("FAIL invalid_cell_req got=%b want=0", place_req); end
   endtask

   task automatic test_reject();
      logic [7:0] e;
      exp_place_q.push_back(8'h31);
      player_cor = 8'h31;
      tick(1);
      player_cor = COR_NONE;
      tick(1);
      e = exp_place_q.pop_front();
      // A second click while the request is pending must not disturb it.
      player_cor = 8'h55;
      tick(1);
      player_cor = COR_NONE;
      tick(1);
      total++;
      if (place_req !== 1'b1 || place_cor !== e) begin
         bad++; $display("FAIL blocked_click got=%b/%h want=1/%h", place_req, place_cor, e);
      end
      place_ack = 1'b1;
      place_ok  = 1'b0;
      tick(1);
      place_ack = 1'b0;
      total++;
      if (placed_cnt !== m_placed || state !== PLACE || place_req !== 1'b0) begin
         bad++; $display("FAIL rejected_place got=%0d/%0d/%b want=%0d/%0d/0",
                         placed_cnt, state, place_req, m_placed, PLACE);
      end
      tick(2);
      place_ack = 1'b1;
      place_ok  = 1'b1;
      tick(1);
      place_ack = 1'b0;
      place_ok  = 1'b0;
      total++;
      if (placed_cnt !== m_placed) begin
         bad++; $display("FAIL stray_place_ack got=%0d want=%0d", placed_cnt, m_placed);
      end
   endtask

   task automatic test_fill();
      fill_cells(1, 18);
      total++;
      if (state !== PLACE) begin bad++; $display("FAIL fill_19_state got=%0d want=%0d", state, PLACE); end
      fill_cells(19, 19);
      total++;
      if (state !== READY || placed_cnt !== m_placed) begin
         bad++; $display("FAIL fill_ready got=%0d/%0d want=%0d/%0d", state, placed_cnt, READY, m_placed);
      end
   endtask

   task automatic test_shots();
      first_move = 1'b1;
      press_start();
      total++;
      if (state !== PLAYER_TURN) begin bad++; $display("FAIL first_move_state got=%0d want=%0d", state, PLAYER_TURN); end
      m_phits = '0;
      shot_click(8'h45);
      shot_answer(1'b1);
      total++;
      if (player_hits !== m_phits || state !== PLAYER_TURN || shot_req !== 1'b0) begin
         bad++; $display("FAIL shot_hit got=%0d/%0d/%b want=%0d/%0d/0",
                         player_hits, state, shot_req, m_phits, PLAYER_TURN);
      end
      enemy_cor = 8'h45;
      tick(1);
      enemy_cor = COR_NONE;
      tick(3);
      total++;
      if (shot_req !== 1'b0 || state !== PLAYER_TURN) begin
         bad++; $display("FAIL repeat_cell got=%b/%0d want=0/%0d", shot_req, state, PLAYER_TURN);
      end
      shot_click(8'h46);
      shot_answer(1'b0);
      total++;
      if (state !== ENEMY_TURN || player_hits !== m_phits) begin
         bad++; $display("FAIL shot_miss got=%0d/%0d want=%0d/%0d", state, player_hits, ENEMY_TURN, m_phits);
      end
      shot_ack = 1'b1;
      shot_hit = 1'b1;
      tick(1);
      shot_ack = 1'b0;
      shot_hit = 1'b0;
      total++;
      if (player_hits !== m_phits) begin
         bad++; $display("FAIL stray_shot_ack got=%0d want=%0d", player_hits, m_phits);
      end
   endtask

   task automatic test_enemy_loss();
      m_ehits = '0;
      enemy_strobe(1'b1);
      total++;
      if (enemy_hits !== m_ehits || state !== ENEMY_TURN) begin
         bad++; $display("FAIL enemy_hit got=%0d/%0d want=%0d/%0d", enemy_hits, state, m_ehits, ENEMY_TURN);
      end
      enemy_strobe(1'b0);
      total++;
      if (state !== PLAYER_TURN || enemy_hits !== m_ehits) begin
         bad++; $display("FAIL enemy_miss got=%0d/%0d want=%0d/%0d", state, enemy_hits, PLAYER_TURN, m_ehits);
      end
      shot_click(8'h47);
      shot_answer(1'b0);
      for (int i = 0; i < 18; i++) enemy_strobe(1'b1);
      total++;
      if (enemy_hits !== 5'd19 || state !== ENEMY_TURN) begin
         bad++; $display("FAIL enemy_19 got=%0d/%0d want=19/%0d", enemy_hits, state, ENEMY_TURN);
      end
      enemy_strobe(1'b1);
      total++;
      if (state !== LOSE || enemy_hits !== m_ehits) begin
         bad++; $display("FAIL lose got=%0d/%0d want=%0d/%0d", state, enemy_hits, LOSE, m_ehits);
      end
      press_start();
      total++;
      if (state !== IDLE || {placed_cnt, player_hits, enemy_hits} !== 15'd0) begin
         bad++; $display("FAIL restart got=%0d/%h want=%0d/0", state, {placed_cnt, player_hits, enemy_hits}, IDLE);
      end
   endtask

   task automatic test_reset_mid();
      m_placed = '0;
      m_phits  = '0;
      m_ehits  = '0;
      press_start();
      fill_cells(0, 19);
      first_move = 1'b0;
      press_start();
      total++;
      if (state !== ENEMY_TURN) begin bad++; $display("FAIL second_move_state got=%0d want=%0d", state, ENEMY_TURN); end
      enemy_strobe(1'b0);
      // Cell 45 was fired at in the previous game; the map must have been cleared.
      shot_click(8'h45);
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (shot_req !== 1'b0 || state !== IDLE) begin
         bad++; $display("FAIL async_reset got=%b/%0d want=0/%0d", shot_req, state, IDLE);
      end
      total++;
      if (shot_cor !== COR_NONE) begin bad++; $display("FAIL async_reset_cor got=%h want=ff", shot_cor); end
      tick(1);
      rst = 1'b0;
      tick(2);
      total++;
      if (state !== IDLE || shot_req !== 1'b0) begin
         bad++; $display("FAIL after_reset got=%0d/%b want=%0d/0", state, shot_req, IDLE);
      end
      total++;
      if (exp_place_q.size() + exp_shot_q.size() != 0) begin
         bad++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_place_q.size() + exp_shot_q.size());
      end
   endtask

   initial begin
      rst              = 1'b1;
      start_btn        = 1'b0;
      first_move       = 1'b0;
      player_cor       = COR_NONE;
      enemy_cor        = COR_NONE;
      place_ack        = 1'b0;
      place_ok         = 1'b0;
      shot_ack         = 1'b0;
      shot_hit         = 1'b0;
      enemy_shot_valid = 1'b0;
      enemy_shot_hit   = 1'b0;
      m_placed         = '0;
      m_phits          = '0;
      m_ehits          = '0;

      test_reset();
      test_start();
      test_placement();
      test_reject();
      test_fill();
      test_shots();
      test_enemy_loss();
      test_reset_mid();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/turn_ctrl.md
# turn_ctrl

Game-flow sequencer for Warships. It sits between `player_ctrl`, which produces `start_btn`, `player_cor` and `enemy_cor`, and the board/link datapath. It turns held-button levels into single click events and runs the game phases: ship placement, turn alternation and win/lose. It issues request/acknowledge transactions to the board memory (placement) and to the link (outgoing shots), and keeps hit counters and a record of cells already fired at.

## Interface
Parameters:
- `SHIP_CELLS`, default 20: number of cells to place before the game can start.
- `HITS_TO_WIN`, default 20: hits that end the game (either side).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start_btn` in 1: level from `player_ctrl`, high while the button is held.
- `player_cor` in 8: {x[3:0], y[3:0]} click on own board; `8'hff` = none.
- `enemy_cor` in 8: same encoding, click on enemy board.
- `first_move` in 1: sampled on leaving READY; 1 = local player shoots first.
- `place_req` out 1: placement request to the board memory.
- `place_cor` out 8: cell to place.
- `place_ack` in 1: one-cycle acknowledge from the board memory.
- `place_ok` in 1: valid with `place_ack`; 1 = cell accepted.
- `shot_req` out 1: outgoing shot request to the link.
- `shot_cor` out 8: target cell.
- `shot_ack` in 1: one-cycle result strobe from the link.
- `shot_hit` in 1: valid with `shot_ack`; 1 = hit.
- `enemy_shot_valid` in 1: one-cycle strobe; the opponent fired at us and the board has resolved it.
- `enemy_shot_hit` in 1: valid with `enemy_shot_valid`.
- `state` out 3: current `turn_state_t`.
- `placed_cnt` out 5: number of cells placed so far.
- `player_hits` out 5: hits we have scored.
- `enemy_hits` out 5: hits the opponent has scored.

## Operation
- **Click events.** A click is a cycle where the coordinate is not `8'hff` and the previous cycle's registered value was `8'hff`. `start_press` is the rising edge of `start_btn`.
- **Valid cell.** A coordinate is valid only if both nibbles are ≤ 9. A click on an invalid cell is discarded. Cell index = y*10 + x.
- **States and transitions:**
  - IDLE: `start_press` → PLACE.
  - PLACE: a valid `player_cor` click while `place_req` is low sets `place_req` = 1 and latches `place_cor`. On `place_ack`, `place_req` drops; if `place_ok`, `placed_cnt`++. When `placed_cnt` reaches `SHIP_CELLS` → READY.
  - READY: `start_press` → PLAYER_TURN if `first_move` = 1, otherwise ENEMY_TURN.
  - PLAYER_TURN: a valid `enemy_cor` click on a cell whose `shot_map` bit is clear sets that bit, latches `shot_cor`, raises `shot_req` → SHOT_WAIT. A click on a cell already in `shot_map` is ignored.
  - SHOT_WAIT: `shot_ack` drops `shot_req`.
    - Hit: `player_hits`++. If the new value = `HITS_TO_WIN` → WIN; otherwise → PLAYER_TURN (a hit grants another shot).
    - Miss → ENEMY_TURN.
  - ENEMY_TURN: on `enemy_shot_valid`:
    - Hit: `enemy_hits`++. If the new value = `HITS_TO_WIN` → LOSE; otherwise stay in ENEMY_TURN.
    - Miss → PLAYER_TURN.
  - WIN / LOSE: `start_press` → IDLE and clears `placed_cnt`, both hit counters and `shot_map`.
- **Ignored inputs.** Clicks, acks and enemy strobes that arrive in a state that does not consume them are ignored. An ack arriving with no request pending is ignored.
- **Counters.** All counters are 5-bit and saturate (no wrap-around).

## Timing
- **Reset values:** `state` = IDLE, `place_req` = 0, `shot_req` = 0, `place_cor` = `8'hff`, `shot_cor` = `8'hff`, all counters = 0, `shot_map` = 0, edge registers = `8'hff` / 0. Reset asserted mid-handshake drops the request immediately and asynchronously.
- **Output registering.** All outputs are registered.
- **Click latency.** Click-detect cycle n → `*_req` high and `*_cor` stable in cycle n+1. Both stay constant until the ack.
- **Ack latency.** Ack sampled in cycle m → `req` low, counter updated and new state visible in cycle m+1.
- **Blocked clicks.** A new click in the same cycle as an ack, or while a request is pending, is dropped. The user must release and click again.
- **Back-to-back requests.** The earliest next request is one cycle after a request drops.
- **Start edge.** One held press of `start_btn` produces exactly one transition.

## Structure
- **Package additions (`project_cfg_pkg`):**
  - `turn_state_t`: enum {IDLE, PLACE, READY, PLAYER_TURN, SHOT_WAIT, ENEMY_TURN, WIN, LOSE}, 3 bits.
  - `GRID_CELLS` = 10.
  - `COR_NONE` = `8'hff`.
- **Sub-module `click_edge_det`:** registers one coordinate bus and outputs a one-cycle `click` pulse plus a `cor_valid` flag. It is instantiated twice (player board and enemy board). The `start_btn` edge detector lives inline in `turn_ctrl`.
- **`shot_map`:** a 100-bit register inside `turn_ctrl`.

## Test plan
1. **Reset and start.** Release reset; pulse `start_btn` high for 5 cycles → `state` goes IDLE→PLACE exactly once; `place_req` = 0.
2. **Placement.**
   - `player_cor` = `8'h23` for 10 cycles → single `place_req` with `place_cor` = `8'h23`.
   - `place_ack` with `place_ok` = 1 → `placed_cnt` = 1.
   - Click `8'hA3` → no request.
   - Repeat valid clicks until 20 accepted cells → READY.
3. **Rejected placement.** `place_ack` with `place_ok` = 0 → `placed_cnt` unchanged, state stays PLACE.
4. **Shot sequence.**
   - `first_move` = 1, `start_press` → PLAYER_TURN.
   - `enemy_cor` = `8'h45` → `shot_req` with `shot_cor` = `8'h45`.
   - Ack with hit = 1 → `player_hits` = 1, PLAYER_TURN.
   - Click `8'h45` again → no `shot_req`.
   - Ack a shot on `8'h46` with miss → ENEMY_TURN.
5. **Enemy turn and loss.**
   - In ENEMY_TURN, one hit strobe → stays ENEMY_TURN; one miss → PLAYER_TURN.
   - With `enemy_hits` = 19, a hit strobe → LOSE.
   - `start_press` → IDLE with all counters at 0.
6. **Reset mid-handshake.** Assert `rst` while `shot_req` = 1 → `shot_req` = 0 in the same cycle; `state` = IDLE.
